// File: rtl/accel_pkg.sv
// Shared accelerator types: raw host command, decoded command, dispatcher
// FSM states and the command decode function.
package accel_pkg;

    localparam int UNIT_COUNT = 256;

    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_LOAD    = 2'd1,
        OP_STORE   = 2'd2,
        OP_COMPUTE = 2'd3
    } op_code_e;

    typedef enum logic [1:0] {
        COMP_ADD  = 2'd0,
        COMP_MUL  = 2'd1,
        COMP_MAC  = 2'd2,
        COMP_RELU = 2'd3
    } comp_type_e;

    // Raw command as issued by the host (22 bits).
    typedef struct packed {
        logic [7:0] unit_id;
        logic [5:0] ctrl;
        logic [7:0] cfg;
    } ctrl_packet_t;

    // Decoded command presented to the unit fabric (20 bits).
    typedef struct packed {
        logic [7:0] unit_id;
        op_code_e   op_code;
        comp_type_e comp_type;
        logic [3:0] addr;
        logic [2:0] size;
        logic       valid;
    } decoded_ctrl_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        ISSUE = 2'd2
    } dsp_state_e;

    // Field extraction from a raw command; ctrl[1:0] is reserved and dropped.
    function automatic decoded_ctrl_t decode(input ctrl_packet_t p);
        decoded_ctrl_t d;
        logic [1:0]    reserved_unused;
        reserved_unused = p.ctrl[1:0];
        d.unit_id       = p.unit_id;
        d.op_code       = op_code_e'(p.ctrl[5:4]);
        d.comp_type     = comp_type_e'(p.ctrl[3:2]);
        d.addr          = p.cfg[7:4];
        d.size          = p.cfg[3:1];
        d.valid         = p.cfg[0];
        return d;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with full/empty flags. A push while full is
// accepted only when a pop happens in the same cycle.
module cmd_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Payload storage, written on every accepted push.
    // NOTE: the array is deliberately not reset; count/pointers define which
    // entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap for free because DEPTH is 2**AW.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_dispatcher.sv
// Command dispatcher: buffers host commands, decodes them, drops NOPs,
// stalls in order on busy units and tracks per-unit busy state.
module ctrl_dispatcher
    import accel_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pkt_valid,
    output logic          pkt_ready,
    input  ctrl_packet_t  pkt,
    output logic          dsp_valid,
    input  logic          dsp_ready,
    output decoded_ctrl_t dsp,
    input  logic          done_valid,
    input  logic [7:0]    done_unit_id,
    output logic [8:0]    busy_count,
    output logic          idle,
    output logic          err_spurious
);
    localparam int PKT_W = $bits(ctrl_packet_t);

    dsp_state_e            state;
    dsp_state_e            state_next;
    decoded_ctrl_t         hold_q;
    logic [UNIT_COUNT-1:0] busy;
    logic [PKT_W-1:0]      fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic                  issue;
    logic                  done_hit;
    logic                  done_spur;

    cmd_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pkt_valid && pkt_ready),
        .wdata (pkt),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign pkt_ready = !fifo_full;
    assign idle      = fifo_empty && (state == IDLE) && (busy_count == '0);
    assign done_hit  = done_valid && busy[done_unit_id];
    assign done_spur = done_valid && !busy[done_unit_id];

    // Next-state and output decode for the IDLE -> HOLD -> ISSUE sequence.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        issue      = 1'b0;
        dsp_valid  = 1'b0;
        dsp        = '0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (hold_q.op_code == OP_NOP) begin
                    state_next = IDLE;
                end else if (!busy[hold_q.unit_id]) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                dsp_valid = 1'b1;
                dsp       = hold_q;
                if (dsp_ready) begin
                    issue      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Hold register: captures the decoded FIFO head on each pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (pop) begin
            hold_q <= decode(ctrl_packet_t'(fifo_rdata));
        end
    end

    // Busy bitmap, its population count and the sticky spurious-done flag.
    // The issue set is written after the done clear so issue wins on a tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy         <= '0;
            busy_count   <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (done_hit) busy[done_unit_id]  <= 1'b0;
            if (issue)    busy[hold_q.unit_id] <= 1'b1;
            busy_count <= busy_count + 9'(issue) - 9'(done_hit);
            if (done_spur) err_spurious <= 1'b1;
        end
    end

endmodule
